uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Buffered UART receiver feeding the CPU's memory-mapped UART RX path (0x8000_0000 status, 0x8000_0004 data).
//  Oversamples serial_in, frames 8N1 bytes LSB-first and pushes them into a FIFO.
//  Presents bytes on a ready/valid interface, so back-to-back bytes are not lost while the CPU is busy.
//  Reports sticky framing-error and overrun flags.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  core clock in Hz
//  BAUD_RATE   115200      line rate in baud
//  FIFO_DEPTH  8           byte entries; power of two, >= 2
// PORTS
//  clk             in   1  core clock; all logic on posedge
//  rst             in   1  synchronous, active-high reset
//  serial_in       in   1  asynchronous RX line; idles high
//  data_out        out  8  FIFO head byte; 0 when FIFO empty
//  data_out_valid  out  1  FIFO non-empty
//  data_out_ready  in   1  consumer pops head when valid && ready
//  rx_busy         out  1  FSM not in IDLE
//  frame_err       out  1  sticky: stop bit sampled 0
//  overrun         out  1  sticky: completed byte dropped because FIFO full
//  err_clear       in   1  clears frame_err and overrun
// BEHAVIOUR
//  - Timing constants:
//    SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer division; 434 at defaults).
//    SAMPLE_TIME = SYMBOL_EDGE_TIME/2.
//    Counter width = $clog2(SYMBOL_EDGE_TIME).
//  - 2-flop synchronizer on serial_in; both flops reset to 1. The FSM sees only the synced value rx_s.
//  - FSM states:
//    IDLE: rx_s==0 -> START, counter=0.
//    START: at counter==SAMPLE_TIME-1, rx_s==0 -> DATA (counter=0, bit_idx=0). Otherwise -> IDLE (glitch rejected, nothing pushed).
//    DATA: at counter==SYMBOL_EDGE_TIME-1, shift rx_s into shift[7] (right shift) and bit_idx++. After the 8th bit -> STOP.
//    STOP: at counter==SYMBOL_EDGE_TIME-1, rx_s==1 -> push shift reg, go to IDLE.
//          rx_s==0 -> set frame_err, drop the byte, go to BREAK.
//    BREAK: stay until rx_s==1, then -> IDLE. This gives one error per break; a held-low line is not re-framed.
//  - Counter resets to 0 on each sample point; all samples land mid-bit.
//  - rx_busy = (state != IDLE).
//  - FIFO:
//    count range 0..FIFO_DEPTH; width $clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
//    Pop when data_out_valid && data_out_ready.
//    Push accepted when count<FIFO_DEPTH || pop is in the same cycle. Simultaneous push+pop when full keeps count, with no overrun.
//    Push rejected when full with no pop: byte discarded, overrun set. Stored data untouched.
//    Simultaneous push+pop when empty is impossible (valid=0); the push lands normally.
//  - Latency: data_out_valid rises the cycle after the stop-bit sample. data_out is combinational from the head entry.
//  - Sticky flags: err_clear clears both. If a set event and err_clear occur in the same cycle, set wins.
//  - Reset values: state IDLE, counters 0, shift 0, FIFO empty, data_out 0, data_out_valid 0, rx_busy 0, frame_err 0, overrun 0.
//  - Reset asserted mid-frame discards the partial byte and all FIFO contents.
//    A frame already in progress when rst deasserts is mis-framed or rejected; the receiver recovers on the next idle->start edge.
// STRUCTURE
//  - FSM state encodings: localparams in a shared header uart_defs.vh, reused by the TX side. SYMBOL_EDGE_TIME and SAMPLE_TIME are derived localparams.
//  - Natural sub-module: sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH), ports clk, rst, wr_en, din, full, rd_en, dout, empty.
//  - The synchronizer, FSM, shift register and error flags live in uart_rx_fifo.
// TESTING (defaults: 434 clk/bit; bench drives the line with an ideal 434-cycle bit period)
//  1. Send 0x55, ready=1 -> data_out_valid pulses 1 cycle with data_out=0x55; rx_busy low after stop; no flags.
//  2. Drive serial_in low for 100 cycles, then high -> START rejects the glitch; no push; rx_busy back to 0 by cycle ~220.
//  3. ready=0, send 0x01..0x09 with DEPTH=8 -> overrun=1 after the 9th byte; draining yields 0x01..0x08 in order, then valid=0.
//  4. Send 0xA3 with stop bit 0, then hold low 2 frame times -> frame_err=1 once, no bytes pushed.
//     Line returns high and 0x3C is sent -> 0x3C received. err_clear -> frame_err=0.
//  5. FIFO full; assert ready in the exact cycle a stop bit is sampled -> head popped, new byte appended, count stays 8, overrun=0.
//  6. Assert rst during data bit 4 of a frame with 2 bytes queued -> next cycle all outputs at reset values.
//     A subsequent clean 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared definitions for the buffered UART receiver: receiver state
// encoding, frame geometry and the helper that derives bit timing from the
// clock and baud rate.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Core clocks per bit period (integer division, truncating).
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with an occupancy counter. A write while full is accepted
// only when a read happens in the same cycle, so a full FIFO can stream.
// The head entry is presented combinationally; dout reads 0 when empty.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en, din    write request and data
//   full          FIFO holds DEPTH entries
//   rd_en         read request (ignored when empty)
//   dout          head entry, 0 when empty
//   empty         FIFO holds no entries
// ---------------------------------------------------------------------------
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_BITS,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_rd;
    logic             do_wr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A read frees the slot the write needs, so full+read still accepts.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; dout is gated by empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Buffered 8N1 UART receiver. serial_in is synchronised, framed LSB-first
// with mid-bit sampling, and completed bytes are queued in a FIFO exposed on
// a ready/valid interface. Framing errors and overruns are sticky.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   serial_in       asynchronous RX line, idles high
//   data_out        FIFO head byte, 0 when empty
//   data_out_valid  FIFO non-empty
//   data_out_ready  consumer pops the head when valid && ready
//   rx_busy         receiver is inside a frame (or a break)
//   frame_err       sticky: stop bit sampled low
//   overrun         sticky: completed byte dropped, FIFO full
//   err_clear       clears both sticky flags
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clear
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

    logic                 sync_0;
    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     counter;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;

    logic                 stop_sample;
    logic                 push;
    logic                 pop;
    logic                 set_frame_err;
    logic                 set_overrun;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchroniser; reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_0 <= serial_in;
            rx_s   <= sync_0;
        end
    end

    // Frame receiver. The counter restarts at every sample point, so the
    // half-bit START wait lands all later samples in the middle of each bit.
    // rx_busy is registered alongside every transition into or out of IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            counter <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rx_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    counter <= '0;
                    if (!rx_s) begin
                        state   <= ST_START;
                        rx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (counter == SAMPLE_LAST) begin
                        counter <= '0;
                        if (!rx_s) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (counter == SYMBOL_LAST) begin
                        counter <= '0;
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (counter == SYMBOL_LAST) begin
                        counter <= '0;
                        if (rx_s) begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= ST_BREAK;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it is reported only once.
                    counter <= '0;
                    if (rx_s) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    counter <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // The stop-bit sample decides between pushing the byte and flagging it.
    assign stop_sample   = (state == ST_STOP) && (counter == SYMBOL_LAST);
    assign push          = stop_sample && rx_s;
    assign set_frame_err = stop_sample && !rx_s;
    assign pop           = data_out_valid && data_out_ready;
    assign set_overrun   = push && fifo_full && !pop;

    // Sticky flags; a set event in the same cycle as err_clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err && !err_clear) || set_frame_err;
            overrun   <= (overrun && !err_clear) || set_overrun;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (push),
        .din   (shift),
        .full  (fifo_full),
        .rd_en (pop),
        .dout  (data_out),
        .empty (fifo_empty)
    );

    assign data_out_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo at default timing (434 clocks per bit). A queue
// model of the received bytes and sticky flags is compared with the DUT on
// every cycle, and directed scenarios add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int BIT_CYCLES = 434;
    localparam int FRAME      = 10 * BIT_CYCLES;
    // Start-bit drive edge to stop-bit sample edge: 2 sync flops, 1 cycle to
    // leave IDLE, 217 cycles to mid start bit, then 9 full bit periods.
    localparam int STOP_LAT   = 3 + (BIT_CYCLES / 2) + 9 * BIT_CYCLES;
    localparam int DEPTH      = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       err_clear;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit checking = 1'b0;
    int frame_start = 0;

    // Model state: expected FIFO contents, flags, and one pending frame end.
    logic [7:0] mq[$];
    logic [7:0] got[$];
    bit         m_fe = 1'b0;
    bit         m_ov = 1'b0;
    bit         ev_valid = 1'b0;
    int         ev_cyc = 0;
    logic [7:0] ev_byte = 8'h00;
    logic       ev_stop = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (115200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .rx_busy        (rx_busy),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .err_clear      (err_clear)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 20)
                $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update: on each edge a pending frame completes (push or framing
    // error) and the consumer pops the head if ready was high.
    always @(posedge clk) begin : model
        bit pop;
        bit was_full;
        bit set_fe;
        bit set_ov;
        cyc++;
        if (rst) begin
            mq.delete();
            m_fe     = 1'b0;
            m_ov     = 1'b0;
            ev_valid = 1'b0;
        end else begin
            pop      = (mq.size() != 0) && data_out_ready;
            was_full = (mq.size() == DEPTH);
            set_fe   = 1'b0;
            set_ov   = 1'b0;
            if (pop) void'(mq.pop_front());
            if (ev_valid && cyc == ev_cyc) begin
                ev_valid = 1'b0;
                if (ev_stop) begin
                    if (!was_full || pop) mq.push_back(ev_byte);
                    else set_ov = 1'b1;
                end else begin
                    set_fe = 1'b1;
                end
            end
            if (err_clear) begin
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            if (set_fe) m_fe = 1'b1;
            if (set_ov) m_ov = 1'b1;
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (checking) begin
            check_output("valid", data_out_valid, (mq.size() != 0));
            check_output("data_out", data_out, (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            check_output("frame_err", frame_err, m_fe);
            check_output("overrun", overrun, m_ov);
            if (data_out_valid && data_out_ready) got.push_back(data_out);
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 data_out_ready = v;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
    endtask

    // Drives one frame for len cycles; optional ready pulse and reset pulse
    // at a given cycle offset from the start-bit edge (-1 = none).
    task automatic apply_stimulus(input logic [7:0] b, input logic stop,
                                  input int pulse_at, input int rst_at, input int len);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        frame_start = cyc;
        ev_cyc   = cyc + STOP_LAT;
        ev_byte  = b;
        ev_stop  = stop;
        ev_valid = 1'b1;
        for (int k = 0; k < len; k++) begin
            serial_in = frame[k / BIT_CYCLES];
            if (pulse_at >= 0) begin
                if (k == pulse_at) data_out_ready = 1'b1;
                else if (k == pulse_at + 1) data_out_ready = 1'b0;
            end
            if (rst_at >= 0) begin
                if (k == rst_at) rst = 1'b1;
                else if (k == rst_at + 1) rst = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        serial_in = stop;
    endtask

    initial begin
        int s;
        rst = 1'b1;
        serial_in = 1'b1;
        data_out_ready = 1'b0;
        err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check_output("reset_valid", data_out_valid, 0);
        check_output("reset_data", data_out, 0);
        check_output("reset_busy", rx_busy, 0);
        check_output("reset_frame_err", frame_err, 0);
        check_output("reset_overrun", overrun, 0);

        // Single byte with the consumer ready: one-cycle valid pulse.
        set_ready(1'b1);
        fork
            apply_stimulus(8'h55, 1'b1, -1, -1, FRAME);
            begin
                @(posedge clk);
                #2;
                wait_cyc(frame_start + STOP_LAT - 1);
                check_output("t1_valid_before", data_out_valid, 0);
                wait_cyc(frame_start + STOP_LAT);
                check_output("t1_valid", data_out_valid, 1);
                check_output("t1_data", data_out, 8'h55);
                wait_cyc(frame_start + STOP_LAT + 1);
                check_output("t1_valid_after", data_out_valid, 0);
                wait_cyc(frame_start + STOP_LAT + 4);
                check_output("t1_busy", rx_busy, 0);
                check_output("t1_flags", {frame_err, overrun}, 0);
            end
        join

        // Short low glitch is rejected at the start-bit sample.
        @(posedge clk);
        #1 serial_in = 1'b0;
        s = cyc;
        wait_cyc(s + 50);
        check_output("t2_busy_start", rx_busy, 1);
        wait_cyc(s + 99);
        @(posedge clk);
        #1 serial_in = 1'b1;
        wait_cyc(s + 230);
        check_output("t2_busy_idle", rx_busy, 0);
        check_output("t2_valid", data_out_valid, 0);

        // Nine bytes into an eight-deep FIFO with no consumer.
        set_ready(1'b0);
        got.delete();
        for (int i = 1; i <= 9; i++) apply_stimulus(8'(i), 1'b1, -1, -1, FRAME);
        @(negedge clk);
        check_output("t3_overrun", overrun, 1);
        check_output("t3_head", data_out, 8'h01);

        // Full FIFO, ready pulsed exactly on the stop-bit sample cycle.
        pulse_clear();
        @(negedge clk);
        check_output("t5_overrun_cleared", overrun, 0);
        apply_stimulus(8'h0A, 1'b1, STOP_LAT - 1, -1, FRAME);
        @(negedge clk);
        check_output("t5_overrun", overrun, 0);
        check_output("t5_head", data_out, 8'h02);
        set_ready(1'b1);
        repeat (6) @(posedge clk);
        #1 data_out_ready = 1'b0;
        @(negedge clk);
        check_output("t3_pop_count", got.size(), 7);
        for (int i = 0; i < 7 && i < got.size(); i++)
            check_output("t3_pop_order", got[i], i + 1);
        check_output("t5_head_after_drain", data_out, 8'h08);

        // Reset during data bit 4 with two bytes queued.
        apply_stimulus(8'hF0, 1'b1, -1, 2300, 2302);
        @(negedge clk);
        check_output("t6_valid", data_out_valid, 0);
        check_output("t6_data", data_out, 0);
        check_output("t6_busy", rx_busy, 0);
        check_output("t6_flags", {frame_err, overrun}, 0);
        set_ready(1'b1);
        got.delete();
        apply_stimulus(8'hC3, 1'b1, -1, -1, FRAME);
        repeat (3) @(negedge clk);
        check_output("t6_rx_count", got.size(), 1);
        if (got.size() > 0) check_output("t6_rx_byte", got[0], 8'hC3);
        check_output("t6_empty", data_out_valid, 0);

        // Stop bit low then a held break: exactly one framing error.
        set_ready(1'b0);
        got.delete();
        apply_stimulus(8'hA3, 1'b0, -1, -1, FRAME);
        @(negedge clk);
        check_output("t4_frame_err", frame_err, 1);
        check_output("t4_no_push", data_out_valid, 0);
        repeat (2 * FRAME) @(posedge clk);
        @(negedge clk);
        check_output("t4_break_busy", rx_busy, 1);
        check_output("t4_break_no_push", data_out_valid, 0);
        @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (10) @(negedge clk);
        check_output("t4_idle", rx_busy, 0);
        apply_stimulus(8'h3C, 1'b1, -1, -1, FRAME);
        @(negedge clk);
        check_output("t4_head", data_out, 8'h3C);
        check_output("t4_err_held", frame_err, 1);
        pulse_clear();
        @(negedge clk);
        check_output("t4_err_cleared", frame_err, 0);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        check_output("t4_rx_count", got.size(), 1);
        if (got.size() > 0) check_output("t4_rx_byte", got[0], 8'h3C);
        check_output("t4_empty", data_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
